// File: rtl/scim_seq_pkg.sv
// Shared types and defaults for the SCIM bank sequencer: state encoding,
// default timing parameters and the compute-counter width helper.
package scim_seq_pkg;

   localparam int DEF_SC_LEN     = 64;
   localparam int DEF_LATCH_INT  = 16;
   localparam int DEF_BB_ROWS    = 9;
   localparam int DEF_PIPE_DEPTH = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BBCLR,
      S_BBLOAD,
      S_CTRCLR,
      S_POS,
      S_NEG,
      S_DRAIN,
      S_DONE
   } state_t;

   // Bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/scim_seq_cnt.sv
// Loadable down-counter with terminal-count flag; times the length of each
// sequencer state.
module scim_seq_cnt #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/scim_bank_sequencer.sv
// Per-bank SCIM compute sequencer: buffer clear/load, counter clear, stochastic
// compute window, drain, done. Optional early termination: SCIM_SEQ_ET_ABORT_EN.
module scim_bank_sequencer
   import scim_seq_pkg::*;
#(
   parameter int SC_LEN     = DEF_SC_LEN,
   parameter int LATCH_INT  = DEF_LATCH_INT,
   parameter int BB_ROWS    = DEF_BB_ROWS,
   parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
   input  logic CLK,
   input  logic RESET,
   input  logic start,
   input  logic roi_sel,
   input  logic dual_phase,
   input  logic abort,
`ifdef SCIM_SEQ_ET_ABORT_EN
   input  logic et_all,
`endif
   output logic ready,
   output logic busy,
   output logic done,
   output logic et_hit,
   output logic BB_CLR,
   output logic BB_EN,
   output logic COMP_EN,
   output logic comp_positive_phase,
   output logic SA_Latch,
   output logic BnkCtr_En,
   output logic BnkCtr_Clr,
   output logic BnkCtr_Buffer_Clr,
   output logic BnkCtr_Latch,
   output logic roi_lb_r
);

   localparam int              CC_W       = clog2(SC_LEN * 2);
   localparam logic [CC_W-1:0] LATCH_MASK = CC_W'(LATCH_INT - 1);

   state_t          r_state;
   state_t          w_next;
   logic            r_dual;
   logic [CC_W-1:0] r_cc;
   logic [CC_W-1:0] w_cc_next;
   logic [CC_W-1:0] w_cnt_val;
   logic            w_tc;
   logic            w_cnt_load;
   logic            w_compute;
   logic            w_next_compute;
   logic            w_accept;
   logic            w_et_exit;
   logic            w_latch_next;

   assign w_compute = (r_state == S_POS) || (r_state == S_NEG);

`ifdef SCIM_SEQ_ET_ABORT_EN
   assign w_et_exit = et_all && w_compute && !abort;
`else
   assign w_et_exit = 1'b0;
`endif

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE) begin
         if (start && !abort) w_next = S_BBCLR;
      end else if (abort) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_BBCLR:  if (w_tc) w_next = S_BBLOAD;
            S_BBLOAD: if (w_tc) w_next = S_CTRCLR;
            S_CTRCLR: if (w_tc) w_next = S_POS;
            S_POS: begin
               if (w_et_exit)  w_next = S_DRAIN;
               else if (w_tc)  w_next = r_dual ? S_NEG : S_DRAIN;
            end
            S_NEG:    if (w_et_exit || w_tc) w_next = S_DRAIN;
            S_DRAIN:  if (w_tc) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // Duration counter is reloaded on every state change with the new state's length.
   always_comb begin
      w_cnt_val = '0;
      unique case (w_next)
         S_BBLOAD:     w_cnt_val = CC_W'(BB_ROWS - 1);
         S_POS, S_NEG: w_cnt_val = CC_W'(SC_LEN - 1);
         S_DRAIN:      w_cnt_val = CC_W'(PIPE_DEPTH - 1);
         default:      w_cnt_val = '0;
      endcase
   end

   assign w_cnt_load     = (w_next != r_state);
   assign w_accept       = (r_state == S_IDLE) && (w_next == S_BBCLR);
   assign w_cc_next      = (r_state == S_CTRCLR) ? '0 :
                           (w_compute ? r_cc + CC_W'(1) : r_cc);
   assign w_next_compute = (w_next == S_POS) || (w_next == S_NEG);
   // An early-terminated window still owes the counters one final latch.
   assign w_latch_next   = (w_next_compute && ((w_cc_next & LATCH_MASK) == LATCH_MASK))
                         || (w_et_exit && !BnkCtr_Latch);

   scim_seq_cnt #(.W(CC_W)) u_cnt (
      .CLK    (CLK),
      .RESET  (RESET),
      .i_load (w_cnt_load),
      .i_val  (w_cnt_val),
      .o_tc   (w_tc)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state             <= S_IDLE;
         r_dual              <= 1'b0;
         r_cc                <= '0;
         ready               <= 1'b1;
         busy                <= 1'b0;
         done                <= 1'b0;
         et_hit              <= 1'b0;
         BB_CLR              <= 1'b0;
         BB_EN               <= 1'b0;
         COMP_EN             <= 1'b0;
         comp_positive_phase <= 1'b0;
         SA_Latch            <= 1'b0;
         BnkCtr_En           <= 1'b0;
         BnkCtr_Clr          <= 1'b0;
         BnkCtr_Buffer_Clr   <= 1'b0;
         BnkCtr_Latch        <= 1'b0;
         roi_lb_r            <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cc    <= w_cc_next;

         if (w_accept) begin
            r_dual   <= dual_phase;
            roi_lb_r <= roi_sel;
            et_hit   <= 1'b0;
         end else begin
            if (w_next == S_IDLE) roi_lb_r <= 1'b0;
            if (w_et_exit)        et_hit   <= 1'b1;
         end

         ready               <= (w_next == S_IDLE);
         busy                <= (w_next != S_IDLE);
         done                <= (w_next == S_DONE);
         BB_CLR              <= (w_next == S_BBCLR);
         BB_EN               <= (w_next == S_BBLOAD);
         COMP_EN             <= w_next_compute;
         comp_positive_phase <= (w_next == S_POS);
         SA_Latch            <= w_next_compute;
         BnkCtr_En           <= w_next_compute;
         BnkCtr_Clr          <= (w_next == S_CTRCLR);
         BnkCtr_Buffer_Clr   <= (w_next == S_CTRCLR);
         BnkCtr_Latch        <= w_latch_next;
      end
   end

endmodule

// File: doc/scim_bank_sequencer.md
# scim_bank_sequencer

Per-bank compute sequencer for one SCIM bank. On each accepted job it clears and loads the bank buffer, clears the bank counters, then runs the stochastic compute window (positive phase, optionally negative phase). It pulses the bank-counter latch at fixed intervals, drains the bank's internal pipeline, and reports completion. It drives the FSM-level control inputs of the bank (COMP_EN, comp_positive_phase, SA_Latch, BnkCtr_*, BB_EN/BB_CLR, roi_lb_r) and sits between the global scheduler and one bank instance.

## Interface
- SC_LEN, 64: compute cycles per phase; power of two, 16..256.
- LATCH_INT, 16: compute cycles between BnkCtr_Latch pulses; power of two; divides SC_LEN.
- BB_ROWS, 9: bank-buffer load cycles (BB_EN high).
- PIPE_DEPTH, 3: drain cycles after the last compute cycle; must be ≥1.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  job request; accepted only when ready=1.
- roi_sel  in  1  ROI for the job (0 left, 1 right); captured on accept.
- dual_phase  in  1  1 = positive then negative phase, 0 = positive only; captured on accept.
- abort  in  1  synchronous cancel.
- et_all  in  1  all compute lines early-terminated; only present under the macro.
- ready  out  1  sequencer idle, can accept.
- busy  out  1  equals ~ready.
- done  out  1  one-cycle completion pulse.
- et_hit  out  1  last job ended by early termination; held until the next accept.
- BB_CLR, BB_EN  out  1 each  bank-buffer control.
- COMP_EN, comp_positive_phase, SA_Latch, BnkCtr_En  out  1 each  compute control.
- BnkCtr_Clr, BnkCtr_Buffer_Clr, BnkCtr_Latch  out  1 each  bank-counter control.
- roi_lb_r  out  1  captured roi_sel, held through the whole job.

## Operation
- States are IDLE, BBCLR, BBLOAD, CTRCLR, POS, NEG, DRAIN, DONE. All outputs are registered (Moore).
- IDLE: ready=1. start=1 with abort=0 captures roi_sel and dual_phase, clears et_hit, and moves to BBCLR.
- BBCLR (1 cycle): BB_CLR=1.
- BBLOAD (BB_ROWS cycles): BB_EN=1.
- CTRCLR (1 cycle): BnkCtr_Clr=1 and BnkCtr_Buffer_Clr=1.
- POS (SC_LEN cycles): COMP_EN, SA_Latch, BnkCtr_En and comp_positive_phase all =1. Exits to NEG if dual_phase=1, else to DRAIN.
- NEG (SC_LEN cycles): same as POS but comp_positive_phase=0.
- Compute counter cc runs 0..N-1 across POS+NEG, where N = SC_LEN·(dual_phase?2:1). BnkCtr_Latch=1 in every compute cycle where cc mod LATCH_INT = LATCH_INT-1.
- DRAIN (PIPE_DEPTH cycles): all controls 0.
- DONE (1 cycle): done=1, then IDLE.
- abort=1 in any non-IDLE state: next state is IDLE and all controls drop to 0. No done pulse, no drain. abort and start together in IDLE: abort wins.
- start while busy is ignored; no queuing.
- Inputs change only at accept, because the captured copies are used for the whole job.

## Timing
- Reset: state IDLE, ready=1, busy=0, et_hit=0; every other output 0.
- Defaults, start accepted at cycle T:
  - BB_CLR at T+1.
  - BB_EN T+2..T+10.
  - CTRCLR at T+11.
  - POS T+12..T+75, NEG T+76..T+139.
  - BnkCtr_Latch at T+27, 43, …, 139 (8 pulses).
  - DRAIN T+140..T+142.
  - done at T+143.
  - ready=1 from T+144. A new start is accepted at T+144.
- ready falls at T+1.
- Reset asserted mid-job returns to the reset state immediately. No done pulse.

## Configuration
- SCIM_SEQ_ET_ABORT_EN defined:
  - et_all is sampled in POS/NEG. et_all=1 in compute cycle k makes k the last compute cycle; DRAIN follows.
  - If cycle k did not carry BnkCtr_Latch, the first DRAIN cycle asserts BnkCtr_Latch=1 (the bank's control pipeline keeps it ordered).
  - et_hit is set at the same time.
- SCIM_SEQ_ET_ABORT_EN undefined: the et_all port is absent, the full window always runs, and et_hit is tied 0.

## Structure
- Shared package scim_seq_pkg holds:
  - the state enum;
  - default parameter constants;
  - counter-width function clog2(SC_LEN·2).
- One sub-module, scim_seq_cnt: loadable down-counter with terminal-count flag. It is reused for state duration. The latch cadence comes from the low bits of cc in the top level.

## Test plan
- Defaults, start=1 at T, dual_phase=1, roi_sel=1 -> BB_EN for 9 cycles, COMP_EN for 128 cycles, 8 BnkCtr_Latch pulses at T+27+16i, done at T+143, roi_lb_r=1 throughout.
- dual_phase=0 -> comp_positive_phase=1 for all 64 compute cycles, 4 latch pulses, done at T+79.
- abort=1 at T+50 -> all controls 0 and ready=1 at T+51; no done; a new start at T+51 is accepted.
- start held high during the job, then start and abort together in IDLE -> no extra accept; the sequencer stays IDLE.
- Macro on, et_all=1 at cc=20 (T+32) -> compute ends at T+32, BnkCtr_Latch at T+33, done at T+36, et_hit=1.
- RESET pulse at T+100 -> all outputs immediately at reset values; no done.
